mips_multicycle_control: RTL and testbench
==========================================

// Module: mips_multicycle_control
// PURPOSE
//  Multi-cycle MIPS main controller: the sequencing side that drives the ALU's ALUControl and consumes its ZeroOut.
//  Steps each instruction through fetch/decode/execute/memory/writeback and issues datapath controls each cycle.
//  Sits between the instruction register (Opcode/Funct) and the datapath muxes, register file, memory and ALU.
//  Memory accesses use a ready handshake, so any latency stalls cleanly.
// PARAMETERS
//  ALU_ADD  4'b0010  ALUControl code for add (PC+4, address calc, add/addu/addi/addiu)
//  ALU_SUB  4'b0110  ALUControl code for beq compare (ALU drives ZeroOut)
//  ALU_SLT  4'b0111  ALUControl code for set-on-less-than
// PORTS
//  clk        in   1  clock; all state changes on rising edge
//  rst_n      in   1  asynchronous active-low reset
//  Opcode     in   6  IR[31:26]; stable from DECODE until return to FETCH
//  Funct      in   6  IR[5:0]; same stability rule
//  ZeroOut    in   1  ALU zero flag, valid in the cycle ALUControl=ALU_SUB
//  MemReady   in   1  memory completes the current MemRead/MemWrite this cycle
//  ALUControl out  4  ALU operation select
//  ALUSrcA    out  1  0=PC, 1=register A
//  ALUSrcB    out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  PCSource   out  2  00=ALU result, 01=ALUOut reg, 10=jump target
//  PCWrite    out  1  load PC (unconditional or beq taken)
//  IorD       out  1  memory address: 0=PC, 1=ALUOut
//  MemRead    out  1  memory read request
//  MemWrite   out  1  memory write request
//  IRWrite    out  1  load instruction register
//  RegDst     out  1  write register: 0=rt, 1=rd
//  MemtoReg   out  1  write data: 0=ALUOut, 1=MDR
//  RegWrite   out  1  register file write enable
//  Illegal    out  1  sticky flag: unsupported instruction decoded
//  State      out  4  current state encoding, for debug/verification
// BEHAVIOUR
//  States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXEC 6, RTWB 7, BRANCH 8, IEXEC 9, IWB 10, JUMP 11.
//  Codes 12-15 are unreachable. If entered, the next edge goes to FETCH.
//  Outputs are Moore-decoded from state, plus MemReady/ZeroOut gating where stated.
//  Unlisted outputs are 0; ALUControl defaults to ALU_ADD.
//  Reset: async to FETCH, Illegal=0, latched R-type op=ALU_ADD.
//  Post-reset outputs are the FETCH values: MemRead=1, ALUSrcB=01; IRWrite/PCWrite follow MemReady.
//  FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_ADD, PCSource=00.
//   IRWrite=PCWrite=MemReady. Hold while !MemReady; MemReady -> DECODE.
//  DECODE: ALUSrcA=0, ALUSrcB=11, ALU_ADD (branch target into ALUOut). Next state by opcode:
//   lw 100011, sw 101011 -> MEMADR
//   R-type 000000 with Funct 100000/100001 (add/addu) or 101010 (slt) -> RTEXEC; latches ALU_ADD or ALU_SLT
//   beq 000100 -> BRANCH
//   addi 001000, addiu 001001 -> IEXEC
//   j 000010 -> JUMP
//   anything else -> FETCH and sets Illegal (sticky until rst_n)
//  MEMADR: ALUSrcA=1, ALUSrcB=10, ALU_ADD. lw -> MEMRD, sw -> MEMWR.
//  MEMRD: MemRead=1, IorD=1. Hold until MemReady, then -> MEMWB.
//  MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
//  MEMWR: MemWrite=1, IorD=1. Hold until MemReady, then -> FETCH.
//  RTEXEC: ALUSrcA=1, ALUSrcB=00, ALUControl=latched op -> RTWB.
//  RTWB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
//  BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_SUB, PCSource=01, PCWrite=ZeroOut (same cycle) -> FETCH.
//  IEXEC: ALUSrcA=1, ALUSrcB=10, ALU_ADD -> IWB.
//  IWB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
//  JUMP: PCSource=10, PCWrite=1 -> FETCH.
//  Cycle counts with MemReady always 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
//   Each cycle MemReady is low adds one stall cycle in FETCH/MEMRD/MEMWR.
//  MemRead and MemWrite are never both 1. RegWrite and MemWrite are never both 1.
//  rst_n low mid-instruction (e.g. MEMWR): MemWrite/RegWrite drop immediately (async); no partial writeback completes.
// TESTING
//  1 Reset, MemReady=0 for 3 cycles then 1 -> State=0 for 4 cycles; IRWrite/PCWrite high only on 4th; then State=1.
//  2 add (Opcode=0, Funct=100000), MemReady=1 -> States 0,1,6,7,0; ALUControl=0010 in RTEXEC; RegWrite=1,RegDst=1 in RTWB.
//  3 slt (Funct=101010) -> ALUControl=0111 in RTEXEC; RTWB asserts RegWrite.
//  4 beq: ZeroOut=1 -> PCWrite=1,PCSource=01,ALUControl=0110 in BRANCH; with ZeroOut=0, PCWrite=0 there.
//  5 lw, MemReady low 2 cycles in MEMRD -> States 0,1,2,3,3,3,4,0; MemtoReg=1,RegWrite=1 in MEMWB.
//  6 Opcode=111111 -> DECODE to FETCH and Illegal=1 held; later rst_n low mid-MEMWR -> MemWrite=0, State=0, Illegal=0 at once.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// Control/status bundle between the multi-cycle MIPS controller and its datapath.
// The master side is the controller; the slave side is the datapath (IR, ALU, memory, register file).
interface mips_multicycle_control_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       ZeroOut;
  logic       MemReady;
  logic [3:0] ALUControl;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic       PCWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  Opcode, Funct, ZeroOut, MemReady,
    output ALUControl, ALUSrcA, ALUSrcB, PCSource, PCWrite, IorD,
           MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           Illegal, State
  );

  modport slave (
    output Opcode, Funct, ZeroOut, MemReady,
    input  ALUControl, ALUSrcA, ALUSrcB, PCSource, PCWrite, IorD,
           MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           Illegal, State
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback,
// with memory accesses stalled on MemReady and beq resolved from the ALU zero flag.
module mips_multicycle_control #(
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_SUB = 4'b0110,
  parameter logic [3:0] ALU_SLT = 4'b0111
) (
  input  logic                        clk,
  input  logic                        rst_n,
  mips_multicycle_control_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [3:0] rtOp_q, rtOp_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      rtOp_q    <= ALU_ADD;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      rtOp_q    <= rtOp_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    illegal_d      = illegal_q;
    rtOp_d         = rtOp_q;
    bus.ALUControl = ALU_ADD;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.PCSource   = 2'b00;
    bus.PCWrite    = 1'b0;
    bus.IorD       = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.RegWrite   = 1'b0;

    case (state_q)
      // PC+4 is computed and written in the same cycle the instruction arrives.
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.MemReady;
        bus.PCWrite = bus.MemReady;
        if (bus.MemReady) state_d = S_DECODE;
      end

      // ALUOut speculatively receives the branch target; the R-type op is latched here
      // so RTEXEC does not depend on Funct decoding timing.
      S_DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.Opcode)
          OP_LW, OP_SW:      state_d = S_MEMADR;
          OP_BEQ:            state_d = S_BRANCH;
          OP_ADDI, OP_ADDIU: state_d = S_IEXEC;
          OP_J:              state_d = S_JUMP;
          OP_RTYPE: begin
            if (bus.Funct == FN_ADD || bus.Funct == FN_ADDU) begin
              rtOp_d  = ALU_ADD;
              state_d = S_RTEXEC;
            end else if (bus.Funct == FN_SLT) begin
              rtOp_d  = ALU_SLT;
              state_d = S_RTEXEC;
            end else begin
              illegal_d = 1'b1;
              state_d   = S_FETCH;
            end
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        if (bus.Opcode == OP_SW) state_d = S_MEMWR;
        else                     state_d = S_MEMRD;
      end

      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        if (bus.MemReady) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
        state_d      = S_FETCH;
      end

      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        if (bus.MemReady) state_d = S_FETCH;
      end

      S_RTEXEC: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUControl = rtOp_q;
        state_d        = S_RTWB;
      end

      S_RTWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
        state_d      = S_FETCH;
      end

      // ZeroOut is valid only while the ALU subtracts, so the PC load is gated in this cycle.
      S_BRANCH: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUControl = ALU_SUB;
        bus.PCSource   = 2'b01;
        bus.PCWrite    = bus.ZeroOut;
        state_d        = S_FETCH;
      end

      S_IEXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = S_IWB;
      end

      S_IWB: begin
        bus.RegWrite = 1'b1;
        state_d      = S_FETCH;
      end

      S_JUMP: begin
        bus.PCSource = 2'b10;
        bus.PCWrite  = 1'b1;
        state_d      = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

  assign bus.State   = state_q;
  assign bus.Illegal = illegal_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed, table-driven bench for the multi-cycle MIPS controller: one row per clock cycle,
// followed by a hand-written asynchronous-reset-during-store sequence.
module tb_mips_multicycle_control;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADI = 6'h08;
  localparam logic [5:0] OP_AIU = 6'h09;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_BAD = 6'h3F;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_ADU = 6'h21;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Control word layout: ALUControl[4] ALUSrcA ALUSrcB[2] PCSource[2] PCWrite IorD MemRead MemWrite IRWrite RegDst MemtoReg RegWrite
  localparam logic [16:0] CW_FSTALL = 17'b0010_0_01_00_0_0_1_0_0_0_0_0;
  localparam logic [16:0] CW_FRDY   = 17'b0010_0_01_00_1_0_1_0_1_0_0_0;
  localparam logic [16:0] CW_DEC    = 17'b0010_0_11_00_0_0_0_0_0_0_0_0;
  localparam logic [16:0] CW_MADR   = 17'b0010_1_10_00_0_0_0_0_0_0_0_0;
  localparam logic [16:0] CW_MRD    = 17'b0010_0_00_00_0_1_1_0_0_0_0_0;
  localparam logic [16:0] CW_MWB    = 17'b0010_0_00_00_0_0_0_0_0_0_1_1;
  localparam logic [16:0] CW_MWR    = 17'b0010_0_00_00_0_1_0_1_0_0_0_0;
  localparam logic [16:0] CW_RTADD  = 17'b0010_1_00_00_0_0_0_0_0_0_0_0;
  localparam logic [16:0] CW_RTSLT  = 17'b0111_1_00_00_0_0_0_0_0_0_0_0;
  localparam logic [16:0] CW_RTWB   = 17'b0010_0_00_00_0_0_0_0_0_1_0_1;
  localparam logic [16:0] CW_BRT    = 17'b0110_1_00_01_1_0_0_0_0_0_0_0;
  localparam logic [16:0] CW_BRN    = 17'b0110_1_00_01_0_0_0_0_0_0_0_0;
  localparam logic [16:0] CW_IEX    = 17'b0010_1_10_00_0_0_0_0_0_0_0_0;
  localparam logic [16:0] CW_IWB    = 17'b0010_0_00_00_0_0_0_0_0_0_0_1;
  localparam logic [16:0] CW_JMP    = 17'b0010_0_00_10_1_0_0_0_0_0_0_0;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zero;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] cw;
    logic        ill;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  vec_t vecs[$];

  mips_multicycle_control_if bus ();

  mips_multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] actualCw();
    return {bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.PCWrite, bus.IorD,
            bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite};
  endfunction

  task automatic addRow(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                        input logic rdy, input logic [3:0] st, input logic [16:0] cw,
                        input logic ill);
    vec_t v;
    v.op = op; v.fn = fn; v.zero = zero; v.rdy = rdy;
    v.st = st; v.cw = cw; v.ill = ill;
    vecs.push_back(v);
  endtask

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.Opcode   = v.op;
    bus.Funct    = v.fn;
    bus.ZeroOut  = v.zero;
    bus.MemReady = v.rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] st, input logic [16:0] cw, input logic ill);
    checkValue({tag, " state"},   {28'd0, bus.State}, {28'd0, st});
    checkValue({tag, " ctl"},     {15'd0, actualCw()}, {15'd0, cw});
    checkValue({tag, " illegal"}, {31'd0, bus.Illegal}, {31'd0, ill});
    checkValue({tag, " rd_wr_excl"}, {31'd0, bus.MemRead & bus.MemWrite}, 32'd0);
    checkValue({tag, " rw_wr_excl"}, {31'd0, bus.RegWrite & bus.MemWrite}, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset with MemReady low for 3 FETCH cycles, then an add.
    addRow(OP_R,   FN_ADD, 0, 0, 4'd0,  CW_FSTALL, 0);
    addRow(OP_R,   FN_ADD, 0, 0, 4'd0,  CW_FSTALL, 0);
    addRow(OP_R,   FN_ADD, 0, 0, 4'd0,  CW_FSTALL, 0);
    addRow(OP_R,   FN_ADD, 0, 1, 4'd0,  CW_FRDY,   0);
    addRow(OP_R,   FN_ADD, 0, 1, 4'd1,  CW_DEC,    0);
    addRow(OP_R,   FN_ADD, 0, 1, 4'd6,  CW_RTADD,  0);
    addRow(OP_R,   FN_ADD, 0, 1, 4'd7,  CW_RTWB,   0);
    // slt
    addRow(OP_R,   FN_SLT, 0, 1, 4'd0,  CW_FRDY,   0);
    addRow(OP_R,   FN_SLT, 0, 1, 4'd1,  CW_DEC,    0);
    addRow(OP_R,   FN_SLT, 0, 1, 4'd6,  CW_RTSLT,  0);
    addRow(OP_R,   FN_SLT, 0, 1, 4'd7,  CW_RTWB,   0);
    // beq taken, then not taken
    addRow(OP_BEQ, FN_ADD, 0, 1, 4'd0,  CW_FRDY,   0);
    addRow(OP_BEQ, FN_ADD, 0, 1, 4'd1,  CW_DEC,    0);
    addRow(OP_BEQ, FN_ADD, 1, 1, 4'd8,  CW_BRT,    0);
    addRow(OP_BEQ, FN_ADD, 0, 1, 4'd0,  CW_FRDY,   0);
    addRow(OP_BEQ, FN_ADD, 0, 1, 4'd1,  CW_DEC,    0);
    addRow(OP_BEQ, FN_ADD, 0, 1, 4'd8,  CW_BRN,    0);
    // lw with two MEMRD stall cycles
    addRow(OP_LW,  FN_ADD, 0, 1, 4'd0,  CW_FRDY,   0);
    addRow(OP_LW,  FN_ADD, 0, 1, 4'd1,  CW_DEC,    0);
    addRow(OP_LW,  FN_ADD, 0, 1, 4'd2,  CW_MADR,   0);
    addRow(OP_LW,  FN_ADD, 0, 0, 4'd3,  CW_MRD,    0);
    addRow(OP_LW,  FN_ADD, 0, 0, 4'd3,  CW_MRD,    0);
    addRow(OP_LW,  FN_ADD, 0, 1, 4'd3,  CW_MRD,    0);
    addRow(OP_LW,  FN_ADD, 0, 1, 4'd4,  CW_MWB,    0);
    // sw, addi, addiu, j
    addRow(OP_SW,  FN_ADD, 0, 1, 4'd0,  CW_FRDY,   0);
    addRow(OP_SW,  FN_ADD, 0, 1, 4'd1,  CW_DEC,    0);
    addRow(OP_SW,  FN_ADD, 0, 1, 4'd2,  CW_MADR,   0);
    addRow(OP_SW,  FN_ADD, 0, 1, 4'd5,  CW_MWR,    0);
    addRow(OP_ADI, FN_ADD, 0, 1, 4'd0,  CW_FRDY,   0);
    addRow(OP_ADI, FN_ADD, 0, 1, 4'd1,  CW_DEC,    0);
    addRow(OP_ADI, FN_ADD, 0, 1, 4'd9,  CW_IEX,    0);
    addRow(OP_ADI, FN_ADD, 0, 1, 4'd10, CW_IWB,    0);
    addRow(OP_AIU, FN_ADD, 0, 1, 4'd0,  CW_FRDY,   0);
    addRow(OP_AIU, FN_ADD, 0, 1, 4'd1,  CW_DEC,    0);
    addRow(OP_AIU, FN_ADD, 0, 1, 4'd9,  CW_IEX,    0);
    addRow(OP_AIU, FN_ADD, 0, 1, 4'd10, CW_IWB,    0);
    addRow(OP_J,   FN_ADD, 0, 1, 4'd0,  CW_FRDY,   0);
    addRow(OP_J,   FN_ADD, 0, 1, 4'd1,  CW_DEC,    0);
    addRow(OP_J,   FN_ADD, 0, 1, 4'd11, CW_JMP,    0);
    // Illegal opcode and unsupported funct; flag is sticky
    addRow(OP_BAD, FN_ADD, 0, 1, 4'd0,  CW_FRDY,   0);
    addRow(OP_BAD, FN_ADD, 0, 1, 4'd1,  CW_DEC,    0);
    addRow(OP_R,   FN_SUB, 0, 1, 4'd0,  CW_FRDY,   1);
    addRow(OP_R,   FN_SUB, 0, 1, 4'd1,  CW_DEC,    1);
    addRow(OP_R,   FN_ADU, 0, 1, 4'd0,  CW_FRDY,   1);
    addRow(OP_R,   FN_ADU, 0, 1, 4'd1,  CW_DEC,    1);
    addRow(OP_R,   FN_ADU, 0, 1, 4'd6,  CW_RTADD,  1);
    addRow(OP_R,   FN_ADU, 0, 1, 4'd7,  CW_RTWB,   1);
    // sw that stalls in MEMWR, leaving the DUT mid-store
    addRow(OP_SW,  FN_ADD, 0, 0, 4'd0,  CW_FSTALL, 1);
    addRow(OP_SW,  FN_ADD, 0, 1, 4'd0,  CW_FRDY,   1);
    addRow(OP_SW,  FN_ADD, 0, 1, 4'd1,  CW_DEC,    1);
    addRow(OP_SW,  FN_ADD, 0, 1, 4'd2,  CW_MADR,   1);
    addRow(OP_SW,  FN_ADD, 0, 0, 4'd5,  CW_MWR,    1);

    bus.Opcode   = OP_R;
    bus.Funct    = FN_ADD;
    bus.ZeroOut  = 1'b0;
    bus.MemReady = 1'b0;
    rst_n        = 1'b1;
    #2 rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 4'd0, CW_FSTALL, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("row%0d", i), vecs[i].st, vecs[i].cw, vecs[i].ill);
      @(posedge clk);
      #1;
    end

    // Still in MEMWR (MemReady low); pull reset between edges and expect an immediate drop.
    bus.MemReady = 1'b0;
    checkValue("midwr state", {28'd0, bus.State}, 32'd5);
    checkValue("midwr memwrite", {31'd0, bus.MemWrite}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkValue("async state", {28'd0, bus.State}, 32'd0);
    checkValue("async memwrite", {31'd0, bus.MemWrite}, 32'd0);
    checkValue("async regwrite", {31'd0, bus.RegWrite}, 32'd0);
    checkValue("async illegal", {31'd0, bus.Illegal}, 32'd0);
    checkValue("async memread", {31'd0, bus.MemRead}, 32'd1);
    bus.MemReady = 1'b1;
    @(posedge clk);
    #1;
    checkValue("held reset state", {28'd0, bus.State}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkValue("post reset state", {28'd0, bus.State}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
